sdram_arbiter_rr: RTL and testbench
===================================

SDRAM_ARBITER_RR -- requirements
Module: sdram_arbiter_rr

Interface
REQ-001 SHALL have parameter N_RD, default 2: number of read ports (1..8).
REQ-002 SHALL have parameter ADDR_W, default 26: SDRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 16: read-data width.
REQ-004 SHALL have parameter HALF_BIT, default 23: address bit selecting the buffer half.
REQ-005 SHALL have port clk50, input, 1: sole clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port sw_write_override, input, 1: write port wins every arbitration while high.
REQ-008 SHALL have port rd_req, input, N_RD: per-port read request.
REQ-009 SHALL have port rd_addr, input, N_RD*ADDR_W: packed addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_ack, output, N_RD: per-port completion, one-hot or zero.
REQ-011 SHALL have port rd_data, output, DATA_W: shared read data, valid only with rd_ack.
REQ-012 SHALL have port wr_req, input, 1: write request (write data routed outside this block).
REQ-013 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-014 SHALL have port wr_ack, output, 1: write completion.
REQ-015 SHALL have ports avl_addr (output, ADDR_W), avl_read (output, 1), avl_write (output, 1), avl_rddata (input, DATA_W), avl_ack (input, 1): bus master side.
REQ-016 SHALL have port sd_write_resume, output, 1: one-cycle pulse when the read stream crosses a buffer half.

Function
REQ-017 SHALL implement FSM IDLE, RD, WR; the grant index and address SHALL be registered on leaving IDLE.
REQ-018 In IDLE with any request present, SHALL enter RD or WR next cycle; avl_read/avl_write SHALL assert from that cycle until the cycle avl_ack=1 inclusive, then return to IDLE.
REQ-019 SHALL route avl_ack combinationally to the granted rd_ack bit or wr_ack in the same cycle; rd_data SHALL equal avl_rddata in RD, 0 otherwise.
REQ-020 Write SHALL be granted in IDLE when wr_req=1 and (sw_write_override=1, or rd_req=0, or the last completed transaction was a read); otherwise a read port SHALL be granted.
REQ-021 Read selection SHALL start at the port after the last granted read index, wrapping N_RD-1 to 0.
REQ-022 Once granted, a transaction SHALL run to avl_ack; request deassertion mid-transaction SHALL be ignored (no abort).
REQ-023 avl_ack while in IDLE SHALL be ignored; minimum spacing between transactions SHALL be one IDLE cycle.
REQ-024 On each read grant, SHALL compare granted address[HALF_BIT] to register last_half; if different, pulse sd_write_resume for one cycle and update last_half.
REQ-025 avl_addr SHALL be 0 in IDLE.

Reset
REQ-026 On reset: state IDLE, all outputs 0, last granted read index N_RD-1, last transaction recorded as write, last_half 1.
REQ-027 Reset mid-transaction SHALL drop avl_read/avl_write immediately; no ack SHALL be issued for the aborted transaction.

Configuration
REQ-028 Macro SDRAM_ARB_RR_EN defined: read selection SHALL be round-robin per REQ-021.
REQ-029 Macro SDRAM_ARB_RR_EN undefined: read selection SHALL be fixed priority, lowest index wins; the pointer SHALL not exist.

Structure
REQ-030 Package sdram_arb_pkg SHALL hold the state enum and the default width constants.
REQ-031 Sub-module sdram_rr_picker SHALL be the combinational rotating-priority selector (request vector, pointer -> one-hot grant, valid).

Verification
REQ-032 rd_req=2'b11 held, wr_req=0, avl_ack 2 cycles after each strobe -> grants alternate 0,1,0,1 (RR_EN); 0,0,0 without the macro.
REQ-033 rd_req=2'b01, wr_req=1 held -> transaction order R0, W, R0, W; wr_ack once per write.
REQ-034 sw_write_override=1, rd_req=2'b11, wr_req=1 -> only writes granted; rd_ack stays 0.
REQ-035 Port 0 reads at 0x07FFFFE, then 0x0800000 -> sd_write_resume pulses exactly once, on the second grant; first-ever read at 0x0000000 also pulses.
REQ-036 reset asserted while avl_read=1 before avl_ack -> avl_read=0 asynchronously, no rd_ack; after release, the first grant goes to port 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM read/write arbiter.
// Read selection policy is chosen in the top via SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } arbState_e;

   localparam int DEF_N_RD     = 2;
   localparam int DEF_ADDR_W   = 26;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_HALF_BIT = 23;

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational rotating-priority selector: the search starts at the port
// after ptr_i and wraps, returning a one-hot grant and a valid flag.
module sdram_rr_picker #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          valid_o
);

   logic [PW-1:0] probe;

   // First requester found walking upward from ptr_i+1 wins.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      probe   = '0;
      for (int off = 1; off <= N; off++) begin
         probe = PW'((int'(ptr_i) + off) % N);
         if (!valid_o && req_i[probe]) begin
            grant_o[probe] = 1'b1;
            valid_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// Arbitrates N_RD read ports and one write port onto a single SDRAM master.
// Define SDRAM_ARB_RR_EN for round-robin reads; otherwise lowest index wins.
module sdram_arbiter_rr
   import sdram_arb_pkg::*;
#(
   parameter int N_RD     = DEF_N_RD,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int HALF_BIT = DEF_HALF_BIT
) (
   input  logic                   clk50,
   input  logic                   reset,
   input  logic                   sw_write_override,
   input  logic [N_RD-1:0]        rd_req,
   input  logic [N_RD*ADDR_W-1:0] rd_addr,
   output logic [N_RD-1:0]        rd_ack,
   output logic [DATA_W-1:0]      rd_data,
   input  logic                   wr_req,
   input  logic [ADDR_W-1:0]      wr_addr,
   output logic                   wr_ack,
   output logic [ADDR_W-1:0]      avl_addr,
   output logic                   avl_read,
   output logic                   avl_write,
   input  logic [DATA_W-1:0]      avl_rddata,
   input  logic                   avl_ack,
   output logic                   sd_write_resume
);

   localparam int IDX_W = (N_RD > 1) ? $clog2(N_RD) : 1;

   arbState_e         state_q, state_d;
   logic [IDX_W-1:0]  grantIdx_q, grantIdx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              lastWasRead_q, lastWasRead_d;
   logic              lastHalf_q, lastHalf_d;
   logic              resume_q, resume_d;

   logic [IDX_W-1:0]  ptr;
   logic [N_RD-1:0]   pickOneHot;
   logic              pickValid;
   logic [IDX_W-1:0]  pickIdx;
   logic [ADDR_W-1:0] pickAddr;
   logic              grantWrite;

`ifdef SDRAM_ARB_RR_EN
   logic [IDX_W-1:0]  lastRd_q, lastRd_d;
   assign ptr = lastRd_q;
`else
   // Pinning the search start at the last port makes port 0 always first.
   assign ptr = IDX_W'(N_RD - 1);
`endif

   sdram_rr_picker #(
      .N  (N_RD),
      .PW (IDX_W)
   ) u_picker (
      .req_i   (rd_req),
      .ptr_i   (ptr),
      .grant_o (pickOneHot),
      .valid_o (pickValid)
   );

   always_comb begin
      pickIdx  = '0;
      pickAddr = '0;
      for (int i = 0; i < N_RD; i++) begin
         if (pickOneHot[i]) begin
            pickIdx  = IDX_W'(i);
            pickAddr = rd_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Writes alternate with reads unless the override or an idle read side lets them win.
   assign grantWrite = wr_req & (sw_write_override | ~(|rd_req) | lastWasRead_q);

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grantIdx_q    <= '0;
         addr_q        <= '0;
         lastWasRead_q <= 1'b0;
         lastHalf_q    <= 1'b1;
         resume_q      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
         lastRd_q      <= IDX_W'(N_RD - 1);
`endif
      end else begin
         state_q       <= state_d;
         grantIdx_q    <= grantIdx_d;
         addr_q        <= addr_d;
         lastWasRead_q <= lastWasRead_d;
         lastHalf_q    <= lastHalf_d;
         resume_q      <= resume_d;
`ifdef SDRAM_ARB_RR_EN
         lastRd_q      <= lastRd_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      grantIdx_d    = grantIdx_q;
      addr_d        = addr_q;
      lastWasRead_d = lastWasRead_q;
      lastHalf_d    = lastHalf_q;
      resume_d      = 1'b0;
`ifdef SDRAM_ARB_RR_EN
      lastRd_d      = lastRd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grantWrite) begin
               state_d = WR;
               addr_d  = wr_addr;
            end else if (pickValid) begin
               state_d    = RD;
               grantIdx_d = pickIdx;
               addr_d     = pickAddr;
`ifdef SDRAM_ARB_RR_EN
               lastRd_d   = pickIdx;
`endif
               // The display reader moving into the other buffer half frees the writer.
               if (pickAddr[HALF_BIT] != lastHalf_q) begin
                  resume_d   = 1'b1;
                  lastHalf_d = pickAddr[HALF_BIT];
               end
            end
         end
         RD, WR: begin
            if (avl_ack) begin
               state_d       = IDLE;
               lastWasRead_d = (state_q == RD);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      avl_read  = (state_q == RD);
      avl_write = (state_q == WR);
      avl_addr  = (state_q == IDLE) ? '0 : addr_q;
      wr_ack    = (state_q == WR) && avl_ack;
      rd_data   = (state_q == RD) ? avl_rddata : '0;
      rd_ack    = '0;
      for (int i = 0; i < N_RD; i++) begin
         rd_ack[i] = (state_q == RD) && avl_ack && (grantIdx_q == IDX_W'(i));
      end
   end

   assign sd_write_resume = resume_q;

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Directed bench for sdram_arbiter_rr with a transaction-level reference model.
// Expected grant orders follow SDRAM_ARB_RR_EN when it is defined.
module tb_sdram_arbiter_rr;

   localparam int NR = 2;
   localparam int AW = 26;
   localparam int DW = 16;
   localparam int HB = 23;

   localparam int M_IDLE = 0;
   localparam int M_RD   = 1;
   localparam int M_WR   = 2;

`ifdef SDRAM_ARB_RR_EN
   localparam logic [31:0] EXP_BOTH = 32'h1212;
`else
   localparam logic [31:0] EXP_BOTH = 32'h1111;
`endif

   logic             clk50 = 1'b0;
   logic             reset = 1'b0;
   logic             sw_write_override = 1'b0;
   logic [NR-1:0]    rd_req = '0;
   logic [NR*AW-1:0] rd_addr = '0;
   logic             wr_req = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [DW-1:0]    avl_rddata = '0;
   logic             avl_ack = 1'b0;
   logic [NR-1:0]    rd_ack;
   logic [DW-1:0]    rd_data;
   logic             wr_ack;
   logic [AW-1:0]    avl_addr;
   logic             avl_read;
   logic             avl_write;
   logic             sd_write_resume;

   sdram_arbiter_rr #(
      .N_RD     (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .HALF_BIT (HB)
   ) dut (
      .clk50             (clk50),
      .reset             (reset),
      .sw_write_override (sw_write_override),
      .rd_req            (rd_req),
      .rd_addr           (rd_addr),
      .rd_ack            (rd_ack),
      .rd_data           (rd_data),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_ack            (wr_ack),
      .avl_addr          (avl_addr),
      .avl_read          (avl_read),
      .avl_write         (avl_write),
      .avl_rddata        (avl_rddata),
      .avl_ack           (avl_ack),
      .sd_write_resume   (sd_write_resume)
   );

   always #5 clk50 = ~clk50;

   int          total = 0;
   int          bad = 0;
   bit          checking = 1'b0;
   bit          strayAck = 1'b0;
   int          strobeCnt = 0;
   logic [31:0] dutLog = '0;
   logic [31:0] modelLog = '0;
   int          dutCount = 0;
   int          wrCnt = 0;
   int          rdCnt = 0;
   int          resumeCnt = 0;

   int          mState = M_IDLE;
   int          mIdx = 0;
   logic [AW-1:0] mAddr = '0;
   bit          mLastRead = 1'b0;
   bit          mLastHalf = 1'b1;
   bit          mResume = 1'b0;
`ifdef SDRAM_ARB_RR_EN
   int          mLastRd = NR - 1;
`endif

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int pickPort(input logic [NR-1:0] req);
`ifdef SDRAM_ARB_RR_EN
      for (int k = 1; k <= NR; k++) begin
         int p;
         p = (mLastRd + k) % NR;
         if (req[p]) return p;
      end
`else
      for (int p = 0; p < NR; p++) begin
         if (req[p]) return p;
      end
`endif
      return 0;
   endfunction

   // Memory responder: ack on the third strobe cycle, optional stray ack while idle.
   always @(posedge clk50) begin
      #1;
      if (avl_read || avl_write) strobeCnt++;
      else strobeCnt = 0;
      avl_ack    = ((avl_read || avl_write) && strobeCnt == 3) || (!(avl_read || avl_write) && strayAck);
      avl_rddata = avl_rddata + 16'h0111;
   end

   // Reference model: one transaction at a time, writes alternate with reads.
   always @(posedge clk50 or posedge reset) begin
      if (reset) begin
         mState    = M_IDLE;
         mLastRead = 1'b0;
         mLastHalf = 1'b1;
         mResume   = 1'b0;
`ifdef SDRAM_ARB_RR_EN
         mLastRd   = NR - 1;
`endif
      end else if (mState == M_IDLE) begin
         mResume = 1'b0;
         if (wr_req && (sw_write_override || rd_req == '0 || mLastRead)) begin
            mState   = M_WR;
            mAddr    = wr_addr;
            modelLog = {modelLog[27:0], 4'h9};
         end else if (rd_req != '0) begin
            mIdx     = pickPort(rd_req);
            mState   = M_RD;
            mAddr    = rd_addr[mIdx*AW +: AW];
            modelLog = {modelLog[27:0], 4'(mIdx + 1)};
`ifdef SDRAM_ARB_RR_EN
            mLastRd  = mIdx;
`endif
            if (mAddr[HB] != mLastHalf) begin
               mResume   = 1'b1;
               mLastHalf = mAddr[HB];
            end
         end
      end else begin
         mResume = 1'b0;
         if (avl_ack) begin
            mLastRead = (mState == M_RD);
            mState    = M_IDLE;
         end
      end
   end

   always @(negedge clk50) begin
      if (checking) begin
         logic [NR-1:0] eRdAck;
         eRdAck = '0;
         if (mState == M_RD && avl_ack) eRdAck[mIdx] = 1'b1;
         checkOutput("avl_read", avl_read, mState == M_RD);
         checkOutput("avl_write", avl_write, mState == M_WR);
         checkOutput("avl_addr", avl_addr, (mState == M_IDLE) ? '0 : mAddr);
         checkOutput("rd_ack", rd_ack, eRdAck);
         checkOutput("wr_ack", wr_ack, mState == M_WR && avl_ack);
         checkOutput("rd_data", rd_data, (mState == M_RD) ? avl_rddata : '0);
         checkOutput("sd_write_resume", sd_write_resume, mResume);
         for (int i = 0; i < NR; i++) begin
            if (rd_ack[i]) begin
               dutLog = {dutLog[27:0], 4'(i + 1)};
               dutCount++;
               rdCnt++;
            end
         end
         if (wr_ack) begin
            dutLog = {dutLog[27:0], 4'h9};
            dutCount++;
            wrCnt++;
         end
         if (sd_write_resume) resumeCnt++;
      end
   end

   task automatic clearLogs();
      dutLog    = '0;
      modelLog  = '0;
      dutCount  = 0;
      wrCnt     = 0;
      rdCnt     = 0;
      resumeCnt = 0;
   endtask

   task automatic doReset();
      @(posedge clk50);
      #1;
      reset             = 1'b1;
      checking          = 1'b1;
      rd_req            = '0;
      wr_req            = 1'b0;
      sw_write_override = 1'b0;
      repeat (2) @(posedge clk50);
      #1;
      reset = 1'b0;
      clearLogs();
   endtask

   task automatic applyStimulus(input logic [NR-1:0] req, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic wreq,
                                input logic [AW-1:0] wa, input logic ovr);
      rd_req               = req;
      rd_addr[0*AW +: AW]  = a0;
      rd_addr[1*AW +: AW]  = a1;
      wr_req               = wreq;
      wr_addr              = wa;
      sw_write_override    = ovr;
   endtask

   task automatic runUntil(input int target, input string name);
      int c;
      c = 0;
      while (dutCount < target && c < 60) begin
         @(posedge clk50);
         #1;
         c++;
      end
      if (dutCount < target) checkOutput(name, dutCount, target);
      rd_req            = '0;
      wr_req            = 1'b0;
      sw_write_override = 1'b0;
      repeat (3) @(posedge clk50);
      #1;
   endtask

   task automatic waitStrobe(input string name);
      int c;
      c = 0;
      while (!(avl_read || avl_write) && c < 20) begin
         @(posedge clk50);
         #1;
         c++;
      end
      if (!(avl_read || avl_write)) checkOutput(name, 0, 1);
   endtask

   initial begin
      logic [AW-1:0] halfAddr [4];
      int            halfExp [4];
      halfAddr = '{26'h0000000, 26'h07FFFFE, 26'h0800000, 26'h0800001};
      halfExp  = '{1, 1, 2, 2};

      doReset();
      checkOutput("rst_avl_read", avl_read, 0);
      checkOutput("rst_avl_write", avl_write, 0);
      checkOutput("rst_avl_addr", avl_addr, 0);
      checkOutput("rst_rd_ack", rd_ack, 0);
      checkOutput("rst_wr_ack", wr_ack, 0);
      checkOutput("rst_rd_data", rd_data, 0);
      checkOutput("rst_resume", sd_write_resume, 0);

      strayAck = 1'b1;
      repeat (3) @(posedge clk50);
      #1;
      strayAck = 1'b0;
      repeat (2) @(posedge clk50);
      #1;
      checkOutput("stray_ack_ignored", dutCount, 0);

      applyStimulus(2'b11, 26'h0000000, 26'h0000010, 1'b0, '0, 1'b0);
      runUntil(4, "both_rd_timeout");
      checkOutput("both_rd_order", dutLog, EXP_BOTH);
      checkOutput("both_rd_model_order", modelLog, EXP_BOTH);
      checkOutput("both_rd_resume", resumeCnt, 1);

      doReset();
      applyStimulus(2'b01, 26'h0000100, '0, 1'b1, 26'h0001234, 1'b0);
      runUntil(4, "rw_timeout");
      checkOutput("rw_order", dutLog, 32'h1919);
      checkOutput("rw_model_order", modelLog, 32'h1919);
      checkOutput("rw_wr_ack_count", wrCnt, 2);

      doReset();
      applyStimulus(2'b11, 26'h0000010, 26'h0000020, 1'b1, 26'h0002000, 1'b1);
      runUntil(3, "ovr_timeout");
      checkOutput("ovr_order", dutLog, 32'h999);
      checkOutput("ovr_model_order", modelLog, 32'h999);
      checkOutput("ovr_no_rd_ack", rdCnt, 0);

      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b01, halfAddr[k], '0, 1'b0, '0, 1'b0);
         runUntil(k + 1, "half_timeout");
         checkOutput($sformatf("half_resume_%0d", k), resumeCnt, halfExp[k]);
      end

      doReset();
      applyStimulus(2'b10, '0, 26'h0C00000, 1'b0, '0, 1'b0);
      waitStrobe("drop_strobe_timeout");
      rd_req = '0;
      runUntil(1, "drop_timeout");
      checkOutput("no_abort_port1", dutLog, 32'h2);

      doReset();
      applyStimulus(2'b01, 26'h0000040, '0, 1'b0, '0, 1'b0);
      waitStrobe("abort_strobe_timeout");
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_drop_read", avl_read, 0);
      checkOutput("abort_rd_ack", rd_ack, 0);
      rd_req = '0;
      @(posedge clk50);
      #1;
      reset = 1'b0;
      checkOutput("aborted_not_acked", dutCount, 0);
      clearLogs();
      applyStimulus(2'b11, 26'h0000080, 26'h0000090, 1'b0, '0, 1'b0);
      runUntil(1, "post_reset_timeout");
      checkOutput("post_reset_first_port0", dutLog, 32'h1);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
